// File: rtl/pipe_hazard_if.sv
// Signal bundle between the pipeline control path and pipe_hazard_unit.
// The perf_stall/perf_flush counters exist only when HAZARD_PERF_EN is defined.
interface pipe_hazard_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 3
);
    localparam int SELW = $clog2(DEPTH + 1);

    logic                  id_valid;
    logic [4:0]            id_rs1;
    logic                  id_rs1_re;
    logic [4:0]            id_rs2;
    logic                  id_rs2_re;
    logic [4:0]            id_rd;
    logic                  id_we;
    logic                  id_load;
    logic                  redirect;
    logic [XLEN-1:0]       rf_rd1;
    logic [XLEN-1:0]       rf_rd2;
    logic [DEPTH*XLEN-1:0] fwd_data;

    logic [XLEN-1:0]       op1;
    logic [XLEN-1:0]       op2;
    logic [SELW-1:0]       fwd_sel1;
    logic [SELW-1:0]       fwd_sel2;
    logic                  stall;
    logic                  flush_ifid;
    logic                  bubble;
    logic [DEPTH-1:0]      inflight;
`ifdef HAZARD_PERF_EN
    logic [31:0]           perf_stall;
    logic [31:0]           perf_flush;
`endif

    // Pipeline side: presents the ID instruction and datapath values.
    modport master (
        output id_valid, id_rs1, id_rs1_re, id_rs2, id_rs2_re, id_rd, id_we, id_load,
        output redirect, rf_rd1, rf_rd2, fwd_data,
`ifdef HAZARD_PERF_EN
        input  perf_stall, perf_flush,
`endif
        input  op1, op2, fwd_sel1, fwd_sel2, stall, flush_ifid, bubble, inflight
    );

    modport slave (
        input  id_valid, id_rs1, id_rs1_re, id_rs2, id_rs2_re, id_rd, id_we, id_load,
        input  redirect, rf_rd1, rf_rd2, fwd_data,
`ifdef HAZARD_PERF_EN
        output perf_stall, perf_flush,
`endif
        output op1, op2, fwd_sel1, fwd_sel2, stall, flush_ifid, bubble, inflight
    );
endinterface

// File: rtl/pipe_hazard_unit.sv
// Hazard/forwarding controller: tracks in-flight writes, forwards the youngest match,
// stalls on load-use and squashes on redirect. HAZARD_PERF_EN adds stall/flush counters.
module pipe_hazard_unit #(
    parameter int XLEN     = 32,
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    pipe_hazard_if.slave hz
);
    localparam int SELW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] ent_valid;
    logic [DEPTH-1:0] ent_we;
    logic [DEPTH-1:0] ent_load;
    logic [4:0]       ent_rd [DEPTH];

    logic [SELW-1:0]  sel1;
    logic [SELW-1:0]  sel2;
    logic [XLEN-1:0]  data1;
    logic [XLEN-1:0]  data2;
    logic             load_use1;
    logic             load_use2;
    logic             stall;
    logic             accept;

    // Entry 0 is EX; entries shift toward WB every edge and the oldest falls off.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent_valid <= '0;
            ent_we    <= '0;
            ent_load  <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                ent_rd[k] <= 5'd0;
            end
        end else begin
            for (int k = DEPTH - 1; k > 0; k--) begin
                ent_valid[k] <= ent_valid[k-1];
                ent_we[k]    <= ent_we[k-1];
                ent_load[k]  <= ent_load[k-1];
                ent_rd[k]    <= ent_rd[k-1];
            end
            ent_valid[0] <= accept;
            ent_we[0]    <= hz.id_we;
            ent_load[0]  <= hz.id_load;
            ent_rd[0]    <= hz.id_rd;
        end
    end

    // Scan oldest to youngest so the youngest match is the one left standing.
    always_comb begin
        sel1      = '0;
        sel2      = '0;
        data1     = hz.rf_rd1;
        data2     = hz.rf_rd2;
        load_use1 = 1'b0;
        load_use2 = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (hz.id_valid && hz.id_rs1_re && (hz.id_rs1 != 5'd0) &&
                ent_valid[k] && ent_we[k] && (ent_rd[k] == hz.id_rs1)) begin
                sel1      = SELW'(k + 1);
                data1     = hz.fwd_data[k*XLEN +: XLEN];
                load_use1 = ent_load[k] && (k < LOAD_LAT);
            end
            if (hz.id_valid && hz.id_rs2_re && (hz.id_rs2 != 5'd0) &&
                ent_valid[k] && ent_we[k] && (ent_rd[k] == hz.id_rs2)) begin
                sel2      = SELW'(k + 1);
                data2     = hz.fwd_data[k*XLEN +: XLEN];
                load_use2 = ent_load[k] && (k < LOAD_LAT);
            end
        end
    end

    // A redirect squashes the ID instruction, so a pending load-use no longer matters.
    assign stall  = (load_use1 || load_use2) && !hz.redirect;
    assign accept = hz.id_valid && !stall && !hz.redirect;

    assign hz.op1        = data1;
    assign hz.op2        = data2;
    assign hz.fwd_sel1   = sel1;
    assign hz.fwd_sel2   = sel2;
    assign hz.stall      = stall;
    assign hz.flush_ifid = hz.redirect;
    assign hz.bubble     = stall || hz.redirect;
    assign hz.inflight   = ent_valid & ent_we;

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_q;
    logic [31:0] perf_flush_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            if (stall && !hz.redirect && (perf_stall_q != 32'hFFFF_FFFF)) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
            if (hz.redirect && (perf_flush_q != 32'hFFFF_FFFF)) begin
                perf_flush_q <= perf_flush_q + 32'd1;
            end
        end
    end

    assign hz.perf_stall = perf_stall_q;
    assign hz.perf_flush = perf_flush_q;
`endif
endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Bench for pipe_hazard_unit: table of forwarding/stall vectors on a LOAD_LAT=1 unit,
// plus hand sequences for reset, stall length (LOAD_LAT=1 and 2), redirect and counters.
module tb_pipe_hazard_unit;
    localparam logic [31:0] RF1  = 32'h1111_1111;
    localparam logic [31:0] RF2  = 32'h2222_2222;
    localparam logic [31:0] FWD0 = 32'h0000_000A;
    localparam logic [31:0] FWD1 = 32'h0000_000B;
    localparam logic [31:0] FWD2 = 32'h0000_000C;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    pipe_hazard_if #(.XLEN(32), .DEPTH(3)) ha ();
    pipe_hazard_if #(.XLEN(32), .DEPTH(3)) hb ();

    pipe_hazard_unit #(.XLEN(32), .DEPTH(3), .LOAD_LAT(1)) dut_a (.clk(clk), .rst(rst), .hz(ha));
    pipe_hazard_unit #(.XLEN(32), .DEPTH(3), .LOAD_LAT(2)) dut_b (.clk(clk), .rst(rst), .hz(hb));

    // The LOAD_LAT=2 unit sees exactly the same stimulus as the LOAD_LAT=1 unit.
    assign hb.id_valid  = ha.id_valid;
    assign hb.id_rs1    = ha.id_rs1;
    assign hb.id_rs1_re = ha.id_rs1_re;
    assign hb.id_rs2    = ha.id_rs2;
    assign hb.id_rs2_re = ha.id_rs2_re;
    assign hb.id_rd     = ha.id_rd;
    assign hb.id_we     = ha.id_we;
    assign hb.id_load   = ha.id_load;
    assign hb.redirect  = ha.redirect;
    assign hb.rf_rd1    = ha.rf_rd1;
    assign hb.rf_rd2    = ha.rf_rd2;
    assign hb.fwd_data  = ha.fwd_data;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- vectors and scoreboard ----------------
    typedef struct {
        logic [2:0] v, we, ld;       // bit k describes entry k
        logic [4:0] rd0, rd1, rd2;
        logic       qv;
        logic [4:0] rs1;
        logic       re1;
        logic [4:0] rs2;
        logic       re2;
        logic       redir;
        logic [1:0] sel1, sel2;
        logic       stall;
        logic       chk_op;
    } vec_t;

    typedef struct packed {
        logic        chk_op;
        logic [1:0]  sel1;
        logic [1:0]  sel2;
        logic        stall;
        logic        bubble;
        logic        flush;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [2:0]  inflight;
    } exp_t;

    vec_t vecs [16];
    exp_t exp_q [$];

    function automatic logic [31:0] fwd_val(input logic [1:0] sel, input logic [31:0] rf);
        case (sel)
            2'd1:    return FWD0;
            2'd2:    return FWD1;
            2'd3:    return FWD2;
            default: return rf;
        endcase
    endfunction

    task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [1:0] sel1, input logic [1:0] sel2, input logic stall,
                            input logic redir, input logic chk_op, input logic [2:0] inflight);
        exp_t e;
        e.chk_op   = chk_op;
        e.sel1     = sel1;
        e.sel2     = sel2;
        e.stall    = stall;
        e.bubble   = stall | redir;
        e.flush    = redir;
        e.op1      = fwd_val(sel1, RF1);
        e.op2      = fwd_val(sel2, RF2);
        e.inflight = inflight;
        exp_q.push_back(e);
    endtask

    task automatic sb_check(input string name);
        exp_t e;
        if (exp_q.size() == 0) begin
            check_val({name, ".queue_empty"}, 64'd1, 64'd0);
            return;
        end
        e = exp_q.pop_front();
        check_val({name, ".stall"},    64'(ha.stall),      64'(e.stall));
        check_val({name, ".bubble"},   64'(ha.bubble),     64'(e.bubble));
        check_val({name, ".flush"},    64'(ha.flush_ifid), 64'(e.flush));
        check_val({name, ".inflight"}, 64'(ha.inflight),   64'(e.inflight));
        if (e.chk_op) begin
            check_val({name, ".sel1"}, 64'(ha.fwd_sel1), 64'(e.sel1));
            check_val({name, ".sel2"}, 64'(ha.fwd_sel2), 64'(e.sel2));
            check_val({name, ".op1"},  64'(ha.op1),      64'(e.op1));
            check_val({name, ".op2"},  64'(ha.op2),      64'(e.op2));
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_id(input logic v, input logic [4:0] rs1, input logic re1,
                          input logic [4:0] rs2, input logic re2, input logic [4:0] rd,
                          input logic we, input logic ld, input logic redir);
        ha.id_valid  = v;
        ha.id_rs1    = rs1;
        ha.id_rs1_re = re1;
        ha.id_rs2    = rs2;
        ha.id_rs2_re = re2;
        ha.id_rd     = rd;
        ha.id_we     = we;
        ha.id_load   = ld;
        ha.redirect  = redir;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        rst = 1'b0;
    endtask

    // Drives one instruction through ID for a single edge; it reads nothing, so it never stalls.
    task automatic issue(input logic v, input logic we, input logic ld, input logic [4:0] rd);
        @(negedge clk);
        set_id(v, 5'd0, 1'b0, 5'd0, 1'b0, rd, we, ld, 1'b0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        ha.rf_rd1   = RF1;
        ha.rf_rd2   = RF2;
        ha.fwd_data = {FWD2, FWD1, FWD0};

        vecs[0]  = '{3'b001, 3'b001, 3'b000, 5'd3, 5'd0, 5'd0, 1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 2'd1, 2'd0, 1'b0, 1'b1};
        vecs[1]  = '{3'b011, 3'b011, 3'b000, 5'd3, 5'd3, 5'd0, 1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 2'd1, 2'd0, 1'b0, 1'b1};
        vecs[2]  = '{3'b011, 3'b011, 3'b000, 5'd4, 5'd3, 5'd0, 1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 1'b0, 2'd2, 2'd1, 1'b0, 1'b1};
        vecs[3]  = '{3'b100, 3'b100, 3'b000, 5'd0, 5'd0, 5'd9, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 2'd0, 2'd3, 1'b0, 1'b1};
        vecs[4]  = '{3'b001, 3'b001, 3'b000, 5'd0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1};
        vecs[5]  = '{3'b001, 3'b001, 3'b000, 5'd3, 5'd0, 5'd0, 1'b1, 5'd3, 1'b0, 5'd3, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1};
        vecs[6]  = '{3'b001, 3'b001, 3'b001, 5'd5, 5'd0, 5'd0, 1'b0, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1};
        vecs[7]  = '{3'b001, 3'b001, 3'b001, 5'd7, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 2'd0, 2'd1, 1'b1, 1'b0};
        vecs[8]  = '{3'b010, 3'b010, 3'b010, 5'd0, 5'd7, 5'd0, 1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 2'd2, 2'd0, 1'b0, 1'b1};
        vecs[9]  = '{3'b011, 3'b010, 3'b000, 5'd3, 5'd3, 5'd0, 1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 2'd2, 2'd0, 1'b0, 1'b1};
        vecs[10] = '{3'b010, 3'b011, 3'b000, 5'd3, 5'd3, 5'd0, 1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 2'd2, 2'd0, 1'b0, 1'b1};
        vecs[11] = '{3'b001, 3'b001, 3'b001, 5'd7, 5'd0, 5'd0, 1'b1, 5'd7, 1'b0, 5'd8, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1};
        vecs[12] = '{3'b101, 3'b101, 3'b000, 5'd1, 5'd0, 5'd2, 1'b1, 5'd2, 1'b1, 5'd1, 1'b1, 1'b0, 2'd3, 2'd1, 1'b0, 1'b1};
        vecs[13] = '{3'b011, 3'b011, 3'b001, 5'd7, 5'd7, 5'd0, 1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 2'd1, 2'd0, 1'b1, 1'b0};
        vecs[14] = '{3'b001, 3'b001, 3'b001, 5'd7, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 2'd0, 2'd1, 1'b0, 1'b0};
        vecs[15] = '{3'b100, 3'b100, 3'b100, 5'd0, 5'd0, 5'd5, 1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 2'd3, 2'd3, 1'b0, 1'b1};

        // Reset state while rst is held.
        repeat (2) @(negedge clk);
        check_val("reset.stall",    64'(ha.stall),      64'd0);
        check_val("reset.bubble",   64'(ha.bubble),     64'd0);
        check_val("reset.flush",    64'(ha.flush_ifid), 64'd0);
        check_val("reset.inflight", 64'(ha.inflight),   64'd0);
        check_val("reset.op1",      64'(ha.op1),        64'(RF1));
`ifdef HAZARD_PERF_EN
        check_val("reset.perf_stall", 64'(ha.perf_stall), 64'd0);
        check_val("reset.perf_flush", 64'(ha.perf_flush), 64'd0);
`endif
        rst = 1'b0;

        // Table: load entries 2,1,0 in that order, then present the query in ID.
        for (int i = 0; i < 16; i++) begin
            reset_dut();
            issue(vecs[i].v[2], vecs[i].we[2], vecs[i].ld[2], vecs[i].rd2);
            issue(vecs[i].v[1], vecs[i].we[1], vecs[i].ld[1], vecs[i].rd1);
            issue(vecs[i].v[0], vecs[i].we[0], vecs[i].ld[0], vecs[i].rd0);
            @(negedge clk);
            set_id(vecs[i].qv, vecs[i].rs1, vecs[i].re1, vecs[i].rs2, vecs[i].re2,
                   5'd0, 1'b0, 1'b0, vecs[i].redir);
            push_exp(vecs[i].sel1, vecs[i].sel2, vecs[i].stall, vecs[i].redir,
                     vecs[i].chk_op, vecs[i].v & vecs[i].we);
            #2;
            sb_check($sformatf("vec%0d", i));
        end

        // Asynchronous reset in the middle of a load-use stall.
        reset_dut();
        issue(1'b1, 1'b1, 1'b1, 5'd5);
        @(negedge clk);
        set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        check_val("rst_mid.stall_before", 64'(ha.stall), 64'd1);
        rst = 1'b1;
        #1;
        check_val("rst_mid.stall",    64'(ha.stall),    64'd0);
        check_val("rst_mid.bubble",   64'(ha.bubble),   64'd0);
        check_val("rst_mid.inflight", 64'(ha.inflight), 64'd0);
        check_val("rst_mid.sel1",     64'(ha.fwd_sel1), 64'd0);
        check_val("rst_mid.op1",      64'(ha.op1),      64'(RF1));
        rst = 1'b0;

        // EX forwarding of a distinctive value.
        reset_dut();
        issue(1'b1, 1'b1, 1'b0, 5'd3);
        @(negedge clk);
        ha.fwd_data[31:0] = 32'h0000_1234;
        set_id(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        #2;
        check_val("ex_fwd.sel1",  64'(ha.fwd_sel1), 64'd1);
        check_val("ex_fwd.op1",   64'(ha.op1),      64'h1234);
        check_val("ex_fwd.stall", 64'(ha.stall),    64'd0);
        ha.fwd_data = {FWD2, FWD1, FWD0};

        // Load-use stall length: one cycle with LOAD_LAT=1, two with LOAD_LAT=2.
        reset_dut();
        issue(1'b1, 1'b1, 1'b1, 5'd7);
        @(negedge clk);
        set_id(1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        #2;
        check_val("lu_c1.a_stall",    64'(ha.stall),    64'd1);
        check_val("lu_c1.a_bubble",   64'(ha.bubble),   64'd1);
        check_val("lu_c1.a_inflight", 64'(ha.inflight), 64'b001);
        check_val("lu_c1.b_stall",    64'(hb.stall),    64'd1);
        @(negedge clk);
        check_val("lu_c2.a_stall",    64'(ha.stall),    64'd0);
        check_val("lu_c2.a_sel2",     64'(ha.fwd_sel2), 64'd2);
        check_val("lu_c2.a_op2",      64'(ha.op2),      64'(FWD1));
        check_val("lu_c2.a_inflight", 64'(ha.inflight), 64'b010);
        check_val("lu_c2.b_stall",    64'(hb.stall),    64'd1);
        @(negedge clk);
        check_val("lu_c3.b_stall",    64'(hb.stall),    64'd0);
        check_val("lu_c3.b_sel2",     64'(hb.fwd_sel2), 64'd3);
        check_val("lu_c3.b_op2",      64'(hb.op2),      64'(FWD2));

        // A redirect squashes the instruction in ID, so it never reaches entry 0.
        reset_dut();
        @(negedge clk);
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b1);
        #2;
        check_val("redir.flush",  64'(ha.flush_ifid), 64'd1);
        check_val("redir.bubble", 64'(ha.bubble),     64'd1);
        check_val("redir.stall",  64'(ha.stall),      64'd0);
        @(negedge clk);
        set_id(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        #2;
        check_val("redir_next.sel1",     64'(ha.fwd_sel1), 64'd0);
        check_val("redir_next.op1",      64'(ha.op1),      64'(RF1));
        check_val("redir_next.inflight", 64'(ha.inflight), 64'd0);

`ifdef HAZARD_PERF_EN
        // A load that reads its own destination, held in ID: stalls on alternate cycles.
        reset_dut();
        issue(1'b1, 1'b1, 1'b1, 5'd7);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            set_id(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0);
            #2;
            check_val($sformatf("perf_seq.stall%0d", c), 64'(ha.stall), 64'((c % 2) == 0));
        end
        @(negedge clk);
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        #2;
        check_val("perf.stall_count", 64'(ha.perf_stall), 64'd3);
        check_val("perf.flush_count", 64'(ha.perf_flush), 64'd1);
`endif

        check_val("sb.drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
